thermo_codec_arbiter: RTL and testbench

//  Two-requester, round-robin controller for the shared thermometer encoder/decoder.

---
 rtl/thermo_codec_arbiter.sv | 116 +++++++++++
 tb/tb_thermo_codec_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_codec_arbiter.sv
// rtl/thermo_codec_arbiter.sv - round-robin sequencer for a shared thermometer encoder/decoder
// One job in flight: IDLE accepts, EXEC drives the external codec, RESP holds the result.
module thermo_codec_arbiter #(
  parameter int K = 3,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_op,
  input  logic [W-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_op,
  input  logic [W-1:0] req1_data,
  output logic [K-1:0] enc_a,
  input  logic [W-1:0] enc_q,
  output logic [W-1:0] dec_a,
  input  logic [K-1:0] dec_q,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           rr_ptr;
  logic [W-1:0]   opnd;
  logic           op_q;
  logic           id_q;
  logic           gnt_id;
  logic           accept;
  logic [W-1:0]   opnd_inc;
  logic           legal;
  logic [W-1:0]   dec_ext;

  // Contested grants follow rr_ptr; an uncontested requester always wins.
  assign gnt_id = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // A thermometer code plus one has no bit in common with itself.
  assign opnd_inc = opnd + W'(1);
  assign legal    = ((opnd & opnd_inc) == '0);
  assign dec_ext  = {{(W-K){1'b0}}, dec_q};

  // Operand register feeds the codec continuously, so inputs never glitch.
  assign enc_a = opnd[K-1:0];
  assign dec_a = opnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && state == IDLE) begin
      req0_ready = req0_valid && !gnt_id;
      req1_ready = req1_valid && gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      opnd      <= '0;
      op_q      <= 1'b0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        opnd   <= gnt_id ? req1_data : req0_data;
        op_q   <= gnt_id ? req1_op : req0_op;
        id_q   <= gnt_id;
        rr_ptr <= ~gnt_id;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        if (!op_q) begin
          rsp_data <= enc_q;
          rsp_err  <= 1'b0;
        end else begin
          rsp_data <= legal ? dec_ext : '0;
          rsp_err  <= !legal;
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_thermo_codec_arbiter.sv
// tb/tb_thermo_codec_arbiter.sv - randomized self-checking bench for thermo_codec_arbiter
`timescale 1ns/1ps
module tb_thermo_codec_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_op;
  logic [6:0] req0_data;
  logic       req1_valid, req1_ready, req1_op;
  logic [6:0] req1_data;
  logic [2:0] enc_a;
  logic [6:0] enc_q;
  logic [6:0] dec_a;
  logic [2:0] dec_q;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [6:0] rsp_data;

  int vectors = 0;
  int miscompares = 0;
  logic m_rr;

  thermo_codec_arbiter #(.K(3), .W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_data(req1_data),
    .enc_a(enc_a), .enc_q(enc_q), .dec_a(dec_a), .dec_q(dec_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External codec stand-ins: encoder sets the low enc_a bits, decoder counts ones.
  always_comb begin
    enc_q = '0;
    for (int i = 0; i < 7; i++) enc_q[i] = (i < int'(enc_a));
  end
  assign dec_q = 3'($countones(dec_a));

  // Reference result {err, data} derived from the thermometer definition.
  function automatic logic [7:0] model(input logic op, input logic [6:0] a);
    if (!op) return {1'b0, 7'((1 << a[2:0]) - 1)};
    for (int n = 0; n <= 7; n++)
      if (a == 7'((1 << n) - 1)) return {1'b0, 7'(n)};
    return {1'b1, 7'd0};
  endfunction

  // Starts and ends at a negedge with the DUT idle.
  task automatic job(input logic v0, input logic v1, input logic op0, input logic op1,
                     input logic [6:0] d0, input logic [6:0] d1, input int stall,
                     output logic [6:0] got);
    logic g;
    logic [6:0] opnd;
    logic [7:0] exp;
    logic [9:0] snap;
    req0_valid = v0; req0_op = op0; req0_data = d0;
    req1_valid = v1; req1_op = op1; req1_data = d1;
    rsp_ready = 1'b0;
    #1;
    g = (v0 && v1) ? m_rr : v1;
    opnd = g ? d1 : d0;
    exp = model(g ? op1 : op0, opnd);
    vectors++;
    if ({req0_ready, req1_ready} !== {~g, g}) begin
      miscompares++;
      $display("FAIL grant: ready={%b,%b} expected={%b,%b}", req0_ready, req1_ready, ~g, g);
    end
    m_rr = ~g;
    @(posedge clk); @(negedge clk);
    req0_data = 7'($urandom); req1_data = 7'($urandom);
    req0_op = 1'($urandom); req1_op = 1'($urandom);
    #1;
    vectors++;
    if ({rsp_valid, req0_ready, req1_ready, enc_a, dec_a} !== {3'b000, opnd[2:0], opnd}) begin
      miscompares++;
      $display("FAIL exec: valid=%b ready=%b%b enc_a=%0d dec_a=%h expected valid=0 ready=00 enc_a=%0d dec_a=%h",
               rsp_valid, req0_ready, req1_ready, enc_a, dec_a, opnd[2:0], opnd);
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, g, exp[7], exp[6:0]}) begin
      miscompares++;
      $display("FAIL response: valid=%b id=%b err=%b data=%h expected valid=1 id=%b err=%b data=%h",
               rsp_valid, rsp_id, rsp_err, rsp_data, g, exp[7], exp[6:0]);
    end
    got = rsp_data;
    snap = {rsp_valid, rsp_id, rsp_err, rsp_data};
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready} !== {snap, 2'b00}) begin
        miscompares++;
        $display("FAIL stall: rsp=%h ready=%b%b expected rsp=%h ready=00",
                 {rsp_valid, rsp_id, rsp_err, rsp_data}, req0_ready, req1_ready, snap);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_release: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_data = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready, enc_a, dec_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b id=%b err=%b data=%h ready=%b%b enc_a=%0d dec_a=%h expected all 0",
               rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready, enc_a, dec_a);
    end
    rst_n = 1'b1;
    m_rr = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: rsp_valid=%b expected 0", rsp_valid);
    end
    // Drive a job into RESP, then pull reset between edges.
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 7'd5;
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_resp: rsp_valid=%b expected 1", rsp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b id=%b err=%b data=%h ready=%b%b expected all 0",
               rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 1'b0;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_priority: ready=%b%b expected 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [6:0] got;
    for (int i = 0; i < 4; i++)
      job(1'b1, 1'b1, 1'b0, 1'b0, 7'($urandom), 7'($urandom), 0, got);
    job(1'b0, 1'b1, 1'b1, 1'b1, 7'h00, 7'h0F, 0, got);
    job(1'b0, 1'b1, 1'b1, 1'b1, 7'h00, 7'h3F, 0, got);
    job(1'b1, 1'b1, 1'b1, 1'b1, 7'h01, 7'h03, 0, got);
  endtask

  task automatic test_encode();
    logic [6:0] got;
    job(1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 7'd0, 0, got);
    job(1'b1, 1'b0, 1'b0, 1'b0, 7'h78, 7'd0, 0, got);
  endtask

  task automatic test_decode();
    logic [6:0] got;
    job(1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 7'b0011111, 0, got);
    job(1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 7'b0010111, 0, got);
    job(1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 7'b0000000, 0, got);
    job(1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 7'h7F, 0, got);
    job(1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 7'b1000000, 0, got);
  endtask

  task automatic test_backpressure();
    logic [6:0] got;
    job(1'b1, 1'b1, 1'b1, 1'b0, 7'b0000111, 7'd6, 5, got);
    job(1'b1, 1'b1, 1'b0, 1'b1, 7'd2, 7'b0101010, 3, got);
  endtask

  task automatic test_sweep();
    logic [6:0] t;
    logic [6:0] b;
    for (int i = 0; i < 8; i++) begin
      job(1'b1, 1'b0, 1'b0, 1'b0, 7'(i), 7'd0, 0, t);
      job(1'b0, 1'b1, 1'b0, 1'b1, 7'd0, t, 0, b);
      vectors++;
      if (b !== 7'(i) || rsp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL round_trip: in=%0d thermo=%h back=%0d err=%b expected back=%0d err=0",
                 i, t, b, rsp_err, i);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] got;
    logic v0, v1;
    logic [6:0] d0, d1;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      d0 = ($urandom_range(0, 1) == 0) ? 7'((1 << $urandom_range(0, 7)) - 1) : 7'($urandom);
      d1 = ($urandom_range(0, 1) == 0) ? 7'((1 << $urandom_range(0, 7)) - 1) : 7'($urandom);
      job(v0, v1, 1'($urandom), 1'($urandom), d0, d1, int'($urandom_range(0, 3)), got);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_encode();
    test_decode();
    test_backpressure();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
